// File: rtl/batamateur_pkg.sv
// rtl/batamateur_pkg.sv - shared bus width and fetch state encoding
package batamateur_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_ADDR = 2'd1,
        FS_MEM  = 2'd2,
        FS_INCR = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_watchdog.sv
// rtl/fetch_sequencer_watchdog.sv - loadable down-counter with expire flag
//
// Module fetch_watchdog
//   clk        in   clock
//   resetn     in   synchronous active-low reset
//   load       in   load count from load_value
//   load_value in   reload value
//   dec        in   decrement (saturates at zero)
//   expired    out  count has reached zero
module fetch_watchdog #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer driving PC/MAR/memory strobes
//
// Optional feature macro: FETCH_TIMEOUT_EN (adds TIMEOUT_CYCLES, FETCH_ERR and the watchdog)
//
// Ports
//   CLOCK      in   clock, rising edge
//   RESET      in   synchronous active-low reset
//   START      in   fetch request level, sampled in IDLE and INCR
//   MEM_READY  in   memory word valid on BUS_IN (used in MEM only)
//   BUS_IN     in   shared data bus
//   PC_RW      out  PC direction, constantly read (1)
//   PC_ENABLE  out  PC drives the bus (ADDR)
//   PC_COUNT   out  PC increment (INCR)
//   MAR_LOAD   out  MAR captures the bus (ADDR)
//   MEM_READ   out  memory read request (MEM)
//   IR         out  instruction register
//   IR_VALID   out  one-cycle pulse in INCR
//   BUSY       out  state is not IDLE
//   FETCH_ERR  out  sticky timeout flag (FETCH_TIMEOUT_EN only)
module fetch_sequencer #(
    parameter int DATA_WIDTH = batamateur_pkg::DATA_WIDTH
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  MEM_READY,
    input  logic [DATA_WIDTH-1:0] BUS_IN,
    output logic                  PC_RW,
    output logic                  PC_ENABLE,
    output logic                  PC_COUNT,
    output logic                  MAR_LOAD,
    output logic                  MEM_READ,
    output logic [DATA_WIDTH-1:0] IR,
    output logic                  IR_VALID,
`ifdef FETCH_TIMEOUT_EN
    output logic                  FETCH_ERR,
`endif
    output logic                  BUSY
);

    import batamateur_pkg::*;

    fetch_state_t state;

    // This block never writes the PC.
    assign PC_RW = 1'b1;

`ifdef FETCH_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic wd_expired;

    // Loaded during ADDR so the first MEM cycle sees TIMEOUT_CYCLES-1;
    // expiry in the TIMEOUT_CYCLES-th MEM cycle aborts at that edge.
    fetch_watchdog #(
        .WIDTH(WD_WIDTH)
    ) u_watchdog (
        .clk        (CLOCK),
        .resetn     (RESET),
        .load       (state == FS_ADDR),
        .load_value (WD_WIDTH'(TIMEOUT_CYCLES - 1)),
        .dec        (state == FS_MEM),
        .expired    (wd_expired)
    );
`endif

    // Outputs are registered alongside the state so each strobe lines up
    // with the state it belongs to.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state     <= FS_IDLE;
            IR        <= '0;
            IR_VALID  <= 1'b0;
            PC_ENABLE <= 1'b0;
            PC_COUNT  <= 1'b0;
            MAR_LOAD  <= 1'b0;
            MEM_READ  <= 1'b0;
            BUSY      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            FETCH_ERR <= 1'b0;
`endif
        end else begin
            IR_VALID  <= 1'b0;
            PC_ENABLE <= 1'b0;
            PC_COUNT  <= 1'b0;
            MAR_LOAD  <= 1'b0;
            MEM_READ  <= 1'b0;
            BUSY      <= 1'b0;
            case (state)
                FS_IDLE, FS_INCR: begin
                    if (START) begin
                        state     <= FS_ADDR;
                        PC_ENABLE <= 1'b1;
                        MAR_LOAD  <= 1'b1;
                        BUSY      <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        FETCH_ERR <= 1'b0;
`endif
                    end else begin
                        state <= FS_IDLE;
                    end
                end
                FS_ADDR: begin
                    state    <= FS_MEM;
                    MEM_READ <= 1'b1;
                    BUSY     <= 1'b1;
                end
                FS_MEM: begin
                    if (MEM_READY) begin
                        state    <= FS_INCR;
                        IR       <= BUS_IN;
                        IR_VALID <= 1'b1;
                        PC_COUNT <= 1'b1;
                        BUSY     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (wd_expired) begin
                        state     <= FS_IDLE;
                        FETCH_ERR <= 1'b1;
`endif
                    end else begin
                        MEM_READ <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        MEM_READY = 1'b0;
    logic [15:0] BUS_IN = '0;
    logic        PC_RW, PC_ENABLE, PC_COUNT, MAR_LOAD, MEM_READ;
    logic [15:0] IR;
    logic        IR_VALID, BUSY;
`ifdef FETCH_TIMEOUT_EN
    logic        FETCH_ERR;
`endif

    fetch_sequencer dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .START     (START),
        .MEM_READY (MEM_READY),
        .BUS_IN    (BUS_IN),
        .PC_RW     (PC_RW),
        .PC_ENABLE (PC_ENABLE),
        .PC_COUNT  (PC_COUNT),
        .MAR_LOAD  (MAR_LOAD),
        .MEM_READ  (MEM_READ),
        .IR        (IR),
        .IR_VALID  (IR_VALID),
`ifdef FETCH_TIMEOUT_EN
        .FETCH_ERR (FETCH_ERR),
`endif
        .BUSY      (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pc_count_n = 0;
    int   mem_read_n = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on IR_VALID.
    always @(negedge CLOCK) begin
        if (RESET) begin
            check("no_bus_contention", 32'(PC_ENABLE & MEM_READ), 32'd0);
            check("pc_rw_read", 32'(PC_RW), 32'd1);
            if (PC_COUNT) pc_count_n++;
            if (MEM_READ) mem_read_n++;
            if (IR_VALID) begin
                if (q.size() == 0) begin
                    check("unexpected_ir_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ir_data", 32'(IR), 32'(e.data));
                    check("ir_valid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // One fetch with `waits` MEM wait cycles; IR_VALID expected 3+waits edges later.
    task automatic fetch_one(input logic [15:0] data, input int waits);
        int   c;
        exp_t e;
        c = cyc;
        e.data = data;
        e.cyc  = c + 3 + waits;
        q.push_back(e);
        START     = 1'b1;
        MEM_READY = 1'b0;
        BUS_IN    = data;
        tick();
        START = 1'b0;
        tick();
        repeat (waits) tick();
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        tick();
    endtask

    initial begin
        int pc0, mr0, c;
        exp_t e;

        // 1: reset held two cycles
        RESET = 1'b0;
        tick();
        tick();
        check("rst_ir", 32'(IR), 32'd0);
        check("rst_ir_valid", 32'(IR_VALID), 32'd0);
        check("rst_pc_rw", 32'(PC_RW), 32'd1);
        check("rst_strobes", {28'd0, PC_ENABLE, PC_COUNT, MAR_LOAD, MEM_READ}, 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
`ifdef FETCH_TIMEOUT_EN
        check("rst_fetch_err", 32'(FETCH_ERR), 32'd0);
`endif
        RESET = 1'b1;
        tick();

        // 2: zero-wait fetch
        pc0 = pc_count_n;
        mr0 = mem_read_n;
        START     = 1'b1;
        MEM_READY = 1'b1;
        BUS_IN    = 16'hA5A5;
        c = cyc;
        e.data = 16'hA5A5;
        e.cyc  = c + 3;
        q.push_back(e);
        tick();
        START = 1'b0;
        check("t2_addr_strobes", {29'd0, PC_ENABLE, MAR_LOAD, BUSY}, 32'h7);
        tick();
        check("t2_mem_strobes", {29'd0, PC_ENABLE, MEM_READ, BUSY}, 32'h3);
        tick();
        check("t2_incr_strobes", {29'd0, PC_ENABLE, PC_COUNT, IR_VALID}, 32'h3);
        MEM_READY = 1'b0;
        tick();
        check("t2_idle_busy", 32'(BUSY), 32'd0);
        check("t2_ir_hold", 32'(IR), 32'hA5A5);
        check("t2_pc_count_n", 32'(pc_count_n - pc0), 32'd1);
        check("t2_mem_read_n", 32'(mem_read_n - mr0), 32'd1);

        // 3: four wait cycles
        pc0 = pc_count_n;
        mr0 = mem_read_n;
        fetch_one(16'h1234, 4);
        check("t3_ir", 32'(IR), 32'h1234);
        check("t3_mem_read_n", 32'(mem_read_n - mr0), 32'd5);
        check("t3_pc_count_n", 32'(pc_count_n - pc0), 32'd1);

        // 4: START held, three back-to-back fetches
        pc0 = pc_count_n;
        c = cyc;
        for (int i = 1; i <= 3; i++) begin
            e.data = 16'(i);
            e.cyc  = c + 3 * i;
            q.push_back(e);
        end
        START     = 1'b1;
        MEM_READY = 1'b1;
        BUS_IN    = 16'h0001;
        repeat (3) tick();
        BUS_IN = 16'h0002;
        repeat (3) tick();
        BUS_IN = 16'h0003;
        tick();
        START = 1'b0;
        repeat (3) tick();
        MEM_READY = 1'b0;
        check("t4_pc_count_n", 32'(pc_count_n - pc0), 32'd3);
        check("t4_ir", 32'(IR), 32'h0003);
        check("t4_idle", 32'(BUSY), 32'd0);

        // 5: reset during MEM
        pc0 = pc_count_n;
        START     = 1'b1;
        MEM_READY = 1'b0;
        BUS_IN    = 16'hDEAD;
        tick();
        START = 1'b0;
        tick();
        tick();
        check("t5_in_mem", 32'(MEM_READ), 32'd1);
        RESET = 1'b0;
        tick();
        check("t5_ir_cleared", 32'(IR), 32'd0);
        check("t5_busy", 32'(BUSY), 32'd0);
        check("t5_mem_read", 32'(MEM_READ), 32'd0);
        RESET = 1'b1;
        tick();
        tick();
        check("t5_pc_count_n", 32'(pc_count_n - pc0), 32'd0);
        check("t5_ir_valid", 32'(IR_VALID), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // 6: timeout after 15 MEM cycles
        fetch_one(16'hBEEF, 0);
        c = cyc;
        START     = 1'b1;
        MEM_READY = 1'b0;
        BUS_IN    = 16'h7777;
        tick();
        START = 1'b0;
        while (cyc < c + 16) tick();
        check("t6_still_mem", {30'd0, MEM_READ, FETCH_ERR}, 32'h2);
        tick();
        check("t6_fetch_err", 32'(FETCH_ERR), 32'd1);
        check("t6_idle", 32'(BUSY), 32'd0);
        check("t6_ir_unchanged", 32'(IR), 32'hBEEF);
        tick();
        check("t6_err_sticky", 32'(FETCH_ERR), 32'd1);
        e.data = 16'h5A5A;
        e.cyc  = cyc + 3;
        q.push_back(e);
        START     = 1'b1;
        BUS_IN    = 16'h5A5A;
        tick();
        START     = 1'b0;
        MEM_READY = 1'b1;
        check("t6_err_cleared", 32'(FETCH_ERR), 32'd0);
        tick();
        tick();
        MEM_READY = 1'b0;
        tick();
        check("t6_ir_after", 32'(IR), 32'h5A5A);
`endif

        repeat (4) tick();
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
